// File: rtl/vga_mode_detect_if.sv
// vga_mode_detect_if: sync inputs, init-sequencer handshake and committed
// mode outputs of the VGA mode detector, bundled for the detector (slave)
// and whatever drives the syncs and observes the results (master).
interface vga_mode_detect_if #(
    parameter int LINE_W  = 16,
    parameter int FRAME_W = 12
);
    logic               Hsync_in;
    logic               Vsync_in;
    logic               Init_done;
    logic               Init_reset;
    logic               Pixel_clk_greater_than_65Mhz;
    logic               Mode_valid;
    logic               Sync_lost;
    logic [LINE_W-1:0]  Line_period;
    logic [FRAME_W-1:0] Frame_lines;

    modport master (
        output Hsync_in, Vsync_in, Init_done,
        input  Init_reset, Pixel_clk_greater_than_65Mhz, Mode_valid,
               Sync_lost, Line_period, Frame_lines
    );

    modport slave (
        input  Hsync_in, Vsync_in, Init_done,
        output Init_reset, Pixel_clk_greater_than_65Mhz, Mode_valid,
               Sync_lost, Line_period, Frame_lines
    );
endinterface

// File: rtl/vga_mode_detect.sv
// vga_mode_detect: measures Hsync period and lines per frame, commits a mode
// once it has been steady for several frames, classifies the pixel rate and
// pulses the I2C init sequencer's reset whenever that class changes.
module vga_mode_detect #(
    parameter int LINE_W                = 16,
    parameter int FRAME_W               = 12,
    parameter int LINE_TOL              = 4,
    parameter int STABLE_FRAMES         = 4,
    parameter int HIGH_RATE_LINE_CYCLES = 3900,
    parameter int TIMEOUT_CYCLES        = 60000,
    parameter int INIT_PULSE_CYCLES     = 16
) (
    input logic              Clk,
    input logic              Reset_n,
    vga_mode_detect_if.slave bus
);

    localparam int TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam int PULSE_W = $clog2(INIT_PULSE_CYCLES + 1);
    localparam int STAB_W  = $clog2(STABLE_FRAMES + 1);

    typedef enum logic [1:0] {REINIT, WAIT_DONE, MEASURE, STABLE} state_t;

    function automatic logic [LINE_W-1:0] sat_inc_line(input logic [LINE_W-1:0] x);
        return (&x) ? x : x + LINE_W'(1);
    endfunction

    function automatic logic [FRAME_W-1:0] sat_inc_frame(input logic [FRAME_W-1:0] x);
        return (&x) ? x : x + FRAME_W'(1);
    endfunction

    // Signed one-bit-wider difference so the magnitude never wraps.
    function automatic logic period_close(input logic [LINE_W-1:0] a,
                                          input logic [LINE_W-1:0] b);
        logic signed [LINE_W:0] diff;
        diff = $signed({1'b0, a}) - $signed({1'b0, b});
        if (diff < 0) diff = -diff;
        return diff <= $signed((LINE_W+1)'(LINE_TOL));
    endfunction

    logic h_sync_p0, h_sync_p1, h_sync_p2;
    logic v_sync_p0, v_sync_p1, v_sync_p2;
    logic h_edge, v_edge;

    logic [LINE_W-1:0]  line_cnt, cur_period, prev_period;
    logic [FRAME_W-1:0] hline_cnt, cur_lines, prev_lines;
    logic [TO_W-1:0]    timeout_cnt;
    logic [LINE_W-1:0]  cur_period_nxt, prev_period_nxt;
    logic [FRAME_W-1:0] cur_lines_nxt, prev_lines_nxt;
    logic [TO_W-1:0]    timeout_nxt;
    logic               timeout_hit, frame_match, new_flag;

    state_t             state, state_nxt;
    logic [PULSE_W-1:0] pulse_cnt, pulse_nxt;
    logic [STAB_W-1:0]  stable_cnt, stable_nxt;
    logic               init_reset_r, init_reset_nxt;
    logic               flag_r, flag_nxt;
    logic               mode_valid_r, mode_valid_nxt;
    logic               sync_lost_r, sync_lost_nxt;
    logic [LINE_W-1:0]  line_period_r, line_period_nxt;
    logic [FRAME_W-1:0] frame_lines_r, frame_lines_nxt;

    // Two-flop synchronizers followed by an edge register per sync input.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            h_sync_p0 <= 1'b0;
            h_sync_p1 <= 1'b0;
            h_sync_p2 <= 1'b0;
            v_sync_p0 <= 1'b0;
            v_sync_p1 <= 1'b0;
            v_sync_p2 <= 1'b0;
        end else begin
            h_sync_p0 <= bus.Hsync_in;
            h_sync_p1 <= h_sync_p0;
            h_sync_p2 <= h_sync_p1;
            v_sync_p0 <= bus.Vsync_in;
            v_sync_p1 <= v_sync_p0;
            v_sync_p2 <= v_sync_p1;
        end
    end

    assign h_edge = h_sync_p1 & ~h_sync_p2;
    assign v_edge = v_sync_p1 & ~v_sync_p2;

    // A line that starts on the Vsync edge belongs to the frame just closed.
    assign cur_period_nxt = h_edge ? line_cnt : cur_period;
    assign cur_lines_nxt  = v_edge ? (h_edge ? sat_inc_frame(hline_cnt) : hline_cnt)
                                   : cur_lines;
    assign timeout_nxt    = h_edge ? '0 :
                            (timeout_cnt == TO_W'(TIMEOUT_CYCLES)) ? timeout_cnt
                                                                   : timeout_cnt + TO_W'(1);
    assign timeout_hit    = (timeout_nxt == TO_W'(TIMEOUT_CYCLES));
    assign frame_match    = period_close(cur_period_nxt, prev_period) &&
                            (cur_lines_nxt == prev_lines);
    assign new_flag       = (cur_period_nxt < LINE_W'(HIGH_RATE_LINE_CYCLES));

    // Line period, lines-per-frame and Hsync-timeout counters.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            line_cnt    <= '0;
            hline_cnt   <= '0;
            timeout_cnt <= '0;
            cur_period  <= '0;
            cur_lines   <= '0;
        end else begin
            line_cnt    <= h_edge ? LINE_W'(1) : sat_inc_line(line_cnt);
            if (v_edge)      hline_cnt <= '0;
            else if (h_edge) hline_cnt <= sat_inc_frame(hline_cnt);
            timeout_cnt <= timeout_nxt;
            cur_period  <= cur_period_nxt;
            cur_lines   <= cur_lines_nxt;
        end
    end

    // Mode FSM state and all registered outputs.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state         <= REINIT;
            pulse_cnt     <= '0;
            stable_cnt    <= '0;
            init_reset_r  <= 1'b1;
            flag_r        <= 1'b0;
            mode_valid_r  <= 1'b0;
            sync_lost_r   <= 1'b1;
            line_period_r <= '0;
            frame_lines_r <= '0;
            prev_period   <= '0;
            prev_lines    <= '0;
        end else begin
            state         <= state_nxt;
            pulse_cnt     <= pulse_nxt;
            stable_cnt    <= stable_nxt;
            init_reset_r  <= init_reset_nxt;
            flag_r        <= flag_nxt;
            mode_valid_r  <= mode_valid_nxt;
            sync_lost_r   <= sync_lost_nxt;
            line_period_r <= line_period_nxt;
            frame_lines_r <= frame_lines_nxt;
            prev_period   <= prev_period_nxt;
            prev_lines    <= prev_lines_nxt;
        end
    end

    // Next-state and next-output decisions; timeout outranks frame events.
    always_comb begin
        state_nxt       = state;
        pulse_nxt       = pulse_cnt;
        stable_nxt      = stable_cnt;
        init_reset_nxt  = 1'b0;
        flag_nxt        = flag_r;
        mode_valid_nxt  = mode_valid_r;
        sync_lost_nxt   = h_edge ? 1'b0 : sync_lost_r;
        line_period_nxt = line_period_r;
        frame_lines_nxt = frame_lines_r;
        prev_period_nxt = v_edge ? cur_period_nxt : prev_period;
        prev_lines_nxt  = v_edge ? cur_lines_nxt : prev_lines;

        case (state)
            REINIT: begin
                if (pulse_cnt == PULSE_W'(INIT_PULSE_CYCLES - 1)) begin
                    pulse_nxt = '0;
                    state_nxt = WAIT_DONE;
                end else begin
                    pulse_nxt      = pulse_cnt + PULSE_W'(1);
                    init_reset_nxt = 1'b1;
                end
            end
            WAIT_DONE: begin
                if (bus.Init_done) begin
                    stable_nxt = '0;
                    state_nxt  = MEASURE;
                end
            end
            MEASURE, STABLE: begin
                if (timeout_hit) begin
                    sync_lost_nxt   = 1'b1;
                    mode_valid_nxt  = 1'b0;
                    stable_nxt      = '0;
                    prev_period_nxt = '0;
                    prev_lines_nxt  = '0;
                    state_nxt       = MEASURE;
                end else if (v_edge && !frame_match) begin
                    mode_valid_nxt = 1'b0;
                    stable_nxt     = '0;
                    state_nxt      = MEASURE;
                end else if (v_edge && state == MEASURE) begin
                    if (stable_cnt == STAB_W'(STABLE_FRAMES - 1)) begin
                        stable_nxt      = STAB_W'(STABLE_FRAMES);
                        line_period_nxt = cur_period_nxt;
                        frame_lines_nxt = cur_lines_nxt;
                        if (new_flag != flag_r) begin
                            flag_nxt       = new_flag;
                            mode_valid_nxt = 1'b0;
                            pulse_nxt      = '0;
                            init_reset_nxt = 1'b1;
                            state_nxt      = REINIT;
                        end else begin
                            mode_valid_nxt = 1'b1;
                            state_nxt      = STABLE;
                        end
                    end else begin
                        stable_nxt = stable_cnt + STAB_W'(1);
                    end
                end
            end
            default: begin
                state_nxt = REINIT;
                pulse_nxt = '0;
            end
        endcase
    end

    assign bus.Init_reset                   = init_reset_r;
    assign bus.Pixel_clk_greater_than_65Mhz = flag_r;
    assign bus.Mode_valid                   = mode_valid_r;
    assign bus.Sync_lost                    = sync_lost_r;
    assign bus.Line_period                  = line_period_r;
    assign bus.Frame_lines                  = frame_lines_r;

endmodule

// File: tb/tb_vga_mode_detect.sv
// tb_vga_mode_detect: directed scaled-down video timings (short lines and
// frames) driven into the mode detector, with a simple model of the init
// sequencer answering Init_reset with Init_done.
module tb_vga_mode_detect;

    localparam int LINE_W    = 16;
    localparam int FRAME_W   = 12;
    localparam int TOL       = 4;
    localparam int STAB      = 4;
    localparam int HIGH_RATE = 45;
    localparam int TIMEOUT   = 200;
    localparam int PULSE     = 16;

    logic Clk = 1'b0;
    logic Reset_n;
    logic seq_en = 1'b0;
    int   seq_cnt = 0;
    int   cyc = 0;
    int   last_h_cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   rst_hi_cnt = 0;
    int   rst_rise_cnt = 0;
    logic ir_prev = 1'b0;
    logic flag_at_rise = 1'b0;
    int   hi_base, rise_base;

    vga_mode_detect_if #(.LINE_W(LINE_W), .FRAME_W(FRAME_W)) bus ();

    vga_mode_detect #(
        .LINE_W(LINE_W), .FRAME_W(FRAME_W), .LINE_TOL(TOL),
        .STABLE_FRAMES(STAB), .HIGH_RATE_LINE_CYCLES(HIGH_RATE),
        .TIMEOUT_CYCLES(TIMEOUT), .INIT_PULSE_CYCLES(PULSE)
    ) dut (
        .Clk(Clk),
        .Reset_n(Reset_n),
        .bus(bus)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    // Sequencer model: Done rises 20 cycles after its reset is released.
    always @(posedge Clk) begin
        if (bus.Init_reset) seq_cnt <= 0;
        else if (seq_cnt < 20) seq_cnt <= seq_cnt + 1;
    end
    assign bus.Init_done = seq_en && (seq_cnt == 20) && !bus.Init_reset;

    // Init_reset activity observed on the falling edge.
    always @(negedge Clk) begin
        if (bus.Init_reset) rst_hi_cnt = rst_hi_cnt + 1;
        if (bus.Init_reset && !ir_prev) begin
            rst_rise_cnt = rst_rise_cnt + 1;
            flag_at_rise = bus.Pixel_clk_greater_than_65Mhz;
        end
        ir_prev = bus.Init_reset;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // One frame of `lines` lines of `per` cycles; Vsync rises with the first
    // Hsync (coin=1) or in the middle of the first line (coin=0).
    task automatic frame(input int per, input int lines, input bit coin);
        for (int i = 0; i < lines; i++) begin
            for (int c = 0; c < per; c++) begin
                bus.Hsync_in = (c < 4);
                if (coin) bus.Vsync_in = (i == 0) && (c < 8);
                else      bus.Vsync_in = (i == 0) && (c >= per / 2) && (c < per / 2 + 8);
                if (c == 0) last_h_cyc = cyc;
                tick();
            end
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_init_reset"}, 32'(bus.Init_reset), 32'd1);
        chk({tag, "_flag"},       32'(bus.Pixel_clk_greater_than_65Mhz), 32'd0);
        chk({tag, "_mode_valid"}, 32'(bus.Mode_valid), 32'd0);
        chk({tag, "_sync_lost"},  32'(bus.Sync_lost), 32'd1);
        chk({tag, "_line_period"}, 32'(bus.Line_period), 32'd0);
        chk({tag, "_frame_lines"}, 32'(bus.Frame_lines), 32'd0);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset_n      = 1'b0;
        bus.Hsync_in = 1'b0;
        bus.Vsync_in = 1'b0;
        repeat (3) tick();
        chk_reset_values("rst");

        // Power-up: Init_reset held for exactly PULSE cycles after release.
        Reset_n = 1'b1;
        repeat (PULSE - 1) tick();
        chk("pwr_pulse_last", 32'(bus.Init_reset), 32'd1);
        tick();
        chk("pwr_pulse_end", 32'(bus.Init_reset), 32'd0);
        repeat (30) tick();
        chk("pwr_wait_reset", 32'(bus.Init_reset), 32'd0);
        chk("pwr_wait_valid", 32'(bus.Mode_valid), 32'd0);
        seq_en = 1'b1;
        repeat (3) tick();
        chk("pwr_measure_valid", 32'(bus.Mode_valid), 32'd0);
        hi_base   = rst_hi_cnt;
        rise_base = rst_rise_cnt;

        // Low-rate mode: 53-cycle lines, 6 lines per frame.
        for (int f = 1; f <= 6; f++) begin
            frame(53, 6, 1'b0);
            if (f == 5) chk("m1_f5_valid", 32'(bus.Mode_valid), 32'd0);
        end
        chk("m1_valid", 32'(bus.Mode_valid), 32'd1);
        chk("m1_period", 32'(bus.Line_period), 32'd53);
        chk("m1_lines", 32'(bus.Frame_lines), 32'd6);
        chk("m1_flag", 32'(bus.Pixel_clk_greater_than_65Mhz), 32'd0);
        chk("m1_sync_lost", 32'(bus.Sync_lost), 32'd0);
        chk("m1_no_reinit", 32'(rst_rise_cnt - rise_base), 32'd0);

        // Jitter of exactly the tolerance keeps the mode.
        for (int k = 0; k < 8; k++) frame((k % 2 == 0) ? 57 : 53, 6, 1'b0);
        chk("jit4_valid", 32'(bus.Mode_valid), 32'd1);
        chk("jit4_period", 32'(bus.Line_period), 32'd53);

        // One cycle beyond tolerance never re-stabilises.
        for (int k = 0; k < 8; k++) frame((k % 2 == 0) ? 58 : 53, 6, 1'b0);
        chk("jit5_valid", 32'(bus.Mode_valid), 32'd0);
        chk("jit5_period_held", 32'(bus.Line_period), 32'd53);

        for (int f = 1; f <= 6; f++) begin
            frame(53, 6, 1'b0);
            if (f == 4) chk("restab_f4_valid", 32'(bus.Mode_valid), 32'd0);
        end
        chk("restab_valid", 32'(bus.Mode_valid), 32'd1);

        // Sync loss exactly TIMEOUT cycles after the last Hsync edge event.
        bus.Hsync_in = 1'b0;
        bus.Vsync_in = 1'b0;
        while (cyc < last_h_cyc + 2 + TIMEOUT) tick();
        chk("to_before", 32'(bus.Sync_lost), 32'd0);
        chk("to_before_valid", 32'(bus.Mode_valid), 32'd1);
        tick();
        chk("to_lost", 32'(bus.Sync_lost), 32'd1);
        chk("to_valid", 32'(bus.Mode_valid), 32'd0);
        chk("to_flag_held", 32'(bus.Pixel_clk_greater_than_65Mhz), 32'd0);
        chk("to_period_held", 32'(bus.Line_period), 32'd53);
        chk("to_lines_held", 32'(bus.Frame_lines), 32'd6);

        // Hsync restart clears Sync_lost three cycles later.
        bus.Hsync_in = 1'b1;
        repeat (2) tick();
        chk("restart_c2", 32'(bus.Sync_lost), 32'd1);
        tick();
        chk("restart_c3", 32'(bus.Sync_lost), 32'd0);
        bus.Hsync_in = 1'b0;
        repeat (10) tick();

        // Vsync coincident with Hsync: that line still counts.
        for (int f = 1; f <= 6; f++) begin
            frame(53, 6, 1'b1);
            if (f == 5) chk("coin_f5_valid", 32'(bus.Mode_valid), 32'd0);
        end
        chk("coin_valid", 32'(bus.Mode_valid), 32'd1);
        chk("coin_lines", 32'(bus.Frame_lines), 32'd6);
        chk("coin_period", 32'(bus.Line_period), 32'd53);

        // High-rate mode: 35-cycle lines, 8 lines per frame.
        hi_base   = rst_hi_cnt;
        rise_base = rst_rise_cnt;
        for (int f = 1; f <= 10; f++) begin
            frame(35, 8, 1'b0);
            if (f == 1) chk("sw_f1_valid", 32'(bus.Mode_valid), 32'd1);
            if (f == 2) chk("sw_f2_valid", 32'(bus.Mode_valid), 32'd0);
            if (f == 6) begin
                chk("sw_commit_valid", 32'(bus.Mode_valid), 32'd0);
                chk("sw_flag", 32'(bus.Pixel_clk_greater_than_65Mhz), 32'd1);
                chk("sw_period", 32'(bus.Line_period), 32'd35);
                chk("sw_lines", 32'(bus.Frame_lines), 32'd8);
                chk("sw_pulse_count", 32'(rst_rise_cnt - rise_base), 32'd1);
                chk("sw_pulse_width", 32'(rst_hi_cnt - hi_base), 32'(PULSE));
                chk("sw_flag_at_pulse", 32'(flag_at_rise), 32'd1);
            end
            if (f == 9) chk("sw_f9_valid", 32'(bus.Mode_valid), 32'd0);
        end
        chk("sw_final_valid", 32'(bus.Mode_valid), 32'd1);
        chk("sw_final_flag", 32'(bus.Pixel_clk_greater_than_65Mhz), 32'd1);
        chk("sw_single_pulse", 32'(rst_rise_cnt - rise_base), 32'd1);

        // Asynchronous reset while stable in the high-rate mode.
        Reset_n = 1'b0;
        #2;
        chk_reset_values("midrst");
        tick();
        Reset_n = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
